// File: rtl/shift_load_ctrl.sv
// Two-requester load controller: round-robin grant, then streams the captured word MSB-first
// into an external shift register in 1-bit or 2-bit beats, with abort and done reporting.
module shift_load_ctrl #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             mode0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             mode1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             aborted,
  output logic             sr_shift_en,
  output logic             sr_enable,
  output logic [WIDTH-1:0] sr_data
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBeat1 = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] LastBeat2 = CntW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             mode_q, mode_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             grant0, grant1;
  logic             last_beat;
  logic             in_shift;

  assign last_beat = (cnt_q == (mode_q ? LastBeat2 : LastBeat1));
  assign in_shift  = (state_q == StShift);

  // Round-robin: on a tie the requester not granted last wins; never grant during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && reset) begin
      if (req0 && req1) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      mode_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    mode_d  = mode_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          state_d = StShift;
          cnt_d   = '0;
          id_d    = grant1;
          last_d  = grant1;
          word_d  = grant1 ? data1 : data0;
          mode_d  = grant1 ? mode1 : mode0;
        end
      end
      StShift: begin
        // Working copy shifts so the next beat always sits in the top bits.
        word_d = mode_q ? (word_q << 2) : (word_q << 1);
        if (abort) begin
          state_d = StIdle;
        end else if (last_beat) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    gnt0        = grant0;
    gnt1        = grant1;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    aborted     = in_shift && abort;
    done_id     = ((state_q == StDone) || (in_shift && abort)) ? id_q : 1'b0;
    sr_shift_en = in_shift;
    sr_enable   = in_shift && mode_q;
    sr_data     = '0;
    if (in_shift) begin
      if (mode_q) begin
        sr_data[1:0] = word_q[WIDTH-1 -: 2];
      end else begin
        sr_data[0] = word_q[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Scoreboard bench for shift_load_ctrl: expected beats and completions are queued at stimulus
// time and retired as the DUT streams, with a model of the attached shift register.
module tb_shift_load_ctrl;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         req0, req1, mode0, mode1, abort;
  logic [W-1:0] data0, data1;
  logic         gnt0, gnt1, busy, done, done_id, aborted, sr_shift_en, sr_enable;
  logic [W-1:0] sr_data;

  shift_load_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .mode0      (mode0),
    .req1       (req1),
    .data1      (data1),
    .mode1      (mode1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .aborted    (aborted),
    .sr_shift_en(sr_shift_en),
    .sr_enable  (sr_enable),
    .sr_data    (sr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W:0]   exp_beats[$];  // {sr_enable, sr_data}
  logic [W:0]   exp_done[$];   // {id, word}
  logic [W-1:0] model;
  logic [W+7:0] obs_all;
  bit           g0, g1;
  int           beats_seen = 0;
  int           done_cnt = 0;
  int           abort_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_load(input bit id, input logic [W-1:0] word, input bit mode);
    logic [W:0] e;
    int beats;
    beats = mode ? W / 2 : W;
    for (int k = 0; k < beats; k++) begin
      e = '0;
      e[W] = mode;
      if (mode) e[1:0] = word[W-1-2*k -: 2];
      else      e[0]   = word[W-1-k];
      exp_beats.push_back(e);
    end
    exp_done.push_back({id, word});
  endtask

  // Samples all outputs at the falling edge and retires scoreboard entries.
  task automatic observe();
    logic [W:0] e;
    g0 = gnt0;
    g1 = gnt1;
    obs_all = {gnt0, gnt1, busy, done, done_id, aborted, sr_shift_en, sr_enable, sr_data};
    check("gnt_onehot", {31'b0, gnt0 & gnt1}, 0);
    if (sr_shift_en) begin
      beats_seen++;
      check("busy_shift", {31'b0, busy}, 1);
      check("beat_queue", {31'b0, exp_beats.size() != 0}, 1);
      if (exp_beats.size() != 0) begin
        e = exp_beats.pop_front();
        check("beat", {25'b0, sr_enable, sr_data}, {25'b0, e});
      end
      if (sr_enable) model = {model[W-3:0], sr_data[1:0]};
      else           model = {model[W-2:0], sr_data[0]};
    end else begin
      check("sr_idle", {25'b0, sr_enable, sr_data}, 0);
    end
    if (done) begin
      done_cnt++;
      check("done_queue", {31'b0, exp_done.size() != 0}, 1);
      if (exp_done.size() != 0) begin
        e = exp_done.pop_front();
        check("done_id", {31'b0, done_id}, {31'b0, e[W]});
        check("sr_model", {26'b0, model}, {26'b0, e[W-1:0]});
      end
      check("done_no_abort", {31'b0, aborted}, 0);
    end
    if (aborted) begin
      abort_cnt++;
      check("abort_queue", {31'b0, exp_done.size() != 0}, 1);
      if (exp_done.size() != 0) begin
        e = exp_done.pop_front();
        check("abort_id", {31'b0, done_id}, {31'b0, e[W]});
      end
      exp_beats.delete();
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input bit hold_reqs);
    reset = 1'b0;
    req0  = hold_reqs;
    req1  = hold_reqs;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("rst_outs", {18'b0, obs_all}, 0);
    end
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b1;
  endtask

  // One load from IDLE; abort_beat < 0 means run to completion.
  task automatic do_load(input bit id, input logic [W-1:0] word, input bit mode, input bit both,
                         input int abort_beat, input bit corrupt);
    int n, beats, d0, a0;
    beats = mode ? W / 2 : W;
    push_load(id, word, mode);
    if (both || !id) begin req0 = 1'b1; data0 = word; mode0 = mode; end
    if (both || id)  begin req1 = 1'b1; data1 = word; mode1 = mode; end
    cycle();
    check("gnt", {30'b0, g1, g0}, id ? 2 : 1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (corrupt) begin
      data0 = '0;
      data1 = '0;
      mode0 = ~mode;
      mode1 = ~mode;
    end
    beats_seen = 0;
    d0 = done_cnt;
    a0 = abort_cnt;
    n = 0;
    while (done_cnt == d0 && abort_cnt == a0 && n < 2 * W + 4) begin
      abort = (beats_seen == abort_beat);
      cycle();
      abort = 1'b0;
      n++;
    end
    check("beats", beats_seen, (abort_beat >= 0) ? abort_beat + 1 : beats);
    check("cycles", n, (abort_beat >= 0) ? abort_beat + 1 : beats + 1);
    check("done_n", done_cnt - d0, (abort_beat < 0) ? 1 : 0);
    check("abort_n", abort_cnt - a0, (abort_beat >= 0) ? 1 : 0);
    cycle();
    check("idle_after", {31'b0, busy}, 0);
  endtask

  initial begin
    int gcount, last_g, d0, n;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0; abort = 1'b0;
    data0 = '0; data1 = '0;
    model = '0;

    apply_reset(1'b1);

    abort = 1'b1;
    cycle();
    check("abort_idle", {18'b0, obs_all}, 0);
    abort = 1'b0;

    do_load(1'b0, 6'b101101, 1'b0, 1'b0, -1, 1'b0);
    do_load(1'b1, 6'b110010, 1'b1, 1'b0, -1, 1'b0);
    do_load(1'b0, 6'b101101, 1'b0, 1'b0, -1, 1'b1);

    // Held tie after reset: 0 first, then strict alternation every beats+2 cycles.
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) push_load(i[0], 6'b011011, 1'b1);
    req0 = 1'b1; req1 = 1'b1;
    data0 = 6'b011011; data1 = 6'b011011; mode0 = 1'b1; mode1 = 1'b1;
    gcount = 0;
    last_g = 0;
    d0 = done_cnt;
    for (int c = 0; c < 40 && done_cnt - d0 < 4; c++) begin
      cycle();
      if (g0 || g1) begin
        check("tie_id", {31'b0, g1}, gcount % 2);
        check("tie_gap", c - last_g, (gcount == 0) ? 0 : 5);
        last_g = c;
        gcount++;
        if (gcount == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("tie_grants", gcount, 4);
    check("tie_dones", done_cnt - d0, 4);
    cycle();

    // Abort on beat 2; aborted load still counts for round-robin.
    do_load(1'b0, 6'b101101, 1'b0, 1'b0, 2, 1'b0);
    do_load(1'b1, 6'b100111, 1'b0, 1'b1, -1, 1'b0);
    do_load(1'b1, 6'b111000, 1'b1, 1'b0, 2, 1'b0);

    // Reset mid-load on beat 3.
    push_load(1'b0, 6'b110110, 1'b0);
    req0 = 1'b1; data0 = 6'b110110; mode0 = 1'b0;
    cycle();
    check("gnt_r", {30'b0, g1, g0}, 1);
    req0 = 1'b0;
    beats_seen = 0;
    n = 0;
    while (beats_seen < 3 && n < 20) begin
      cycle();
      n++;
    end
    check("rst_reach", beats_seen, 3);
    reset = 1'b0;
    cycle();
    cycle();
    check("rst_mid", {18'b0, obs_all}, 0);
    exp_beats.delete();
    exp_done.delete();
    reset = 1'b1;
    do_load(1'b1, 6'b110010, 1'b1, 1'b0, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_load(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, -1,
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_load_ctrl.md
SHIFT_LOAD_CTRL -- requirements
Module: shift_load_ctrl

Interface
REQ-001 Parameter: WIDTH, 6, word width of the attached shift register; SHALL be even and >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on the rising clk edge.
REQ-004 req0  input  1  requester 0 load request, held high until granted.
REQ-005 data0  input  WIDTH  requester 0 word to load.
REQ-006 mode0  input  1  requester 0 mode: 1 = 2-bit beats, 0 = 1-bit beats.
REQ-007 req1 / data1 / mode1  input  1 / WIDTH / 1  requester 1, same meaning as requester 0.
REQ-008 gnt0, gnt1  output  1  one-cycle accept pulse; word, mode and id are captured at that cycle's edge.
REQ-009 abort  input  1  cancels the load in progress.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when a load completes.
REQ-012 done_id  output  1  requester index of the completed or aborted load; valid while done or aborted is high.
REQ-013 aborted  output  1  one-cycle pulse when a load is cancelled.
REQ-014 sr_shift_en  output  1  drives the shift register shift-enable input.
REQ-015 sr_enable  output  1  drives the shift register 2-bit-shift select input.
REQ-016 sr_data  output  WIDTH  drives the shift register data input.

Function
REQ-017 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-018 IDLE: if req0 or req1 is high, the block SHALL assert exactly one gnt combinationally in that cycle.
REQ-019 On the gnt edge the block SHALL capture word, mode and id, clear the beat counter and enter SHIFT.
REQ-020 Arbitration SHALL be round-robin: with both requests high, grant goes to the requester not granted last.
REQ-021 With a single request, grant SHALL go to that requester regardless of history.
REQ-022 The last-granted pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-023 SHIFT SHALL last exactly WIDTH cycles in 1-bit mode and WIDTH/2 cycles in 2-bit mode.
REQ-024 sr_shift_en SHALL be high in every SHIFT cycle and low in all other states.
REQ-025 sr_enable SHALL equal the captured mode during SHIFT and be 0 otherwise.
REQ-026 Transmission SHALL be MSB-first.
REQ-027 1-bit mode, beat k (0-based): sr_data[0] = word[WIDTH-1-k].
REQ-028 2-bit mode, beat k: sr_data[1:0] = word[WIDTH-1-2k : WIDTH-2-2k].
REQ-029 Unused sr_data bits SHALL be 0, and all of sr_data SHALL be 0 outside SHIFT.
REQ-030 After the final beat, the attached shift register SHALL hold the captured word exactly.
REQ-031 The beat counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within a load.
REQ-032 Last SHIFT beat -> DONE; DONE lasts one cycle with done=1 and done_id = captured id, then returns to IDLE.
REQ-033 No gnt SHALL be issued in DONE, so the minimum spacing between grants is beats+2 cycles.
REQ-034 Inputs data/mode changing after the grant SHALL NOT affect the load in progress.
REQ-035 abort high in SHIFT SHALL set aborted=1 and done_id = captured id in that cycle.
REQ-036 On that same edge the FSM SHALL go to IDLE; sr_shift_en SHALL still be high in that cycle, so the beat completes.
REQ-037 abort in IDLE or DONE SHALL be ignored; abort in the last beat SHALL take precedence over done.
REQ-038 An aborted load SHALL count as granted for round-robin purposes.

Reset
REQ-039 reset low at a clock edge SHALL force IDLE, clear the beat counter and set the last-granted pointer to 1, including mid-load.
REQ-040 Reset values: gnt0=gnt1=busy=done=done_id=aborted=sr_shift_en=sr_enable=0 and sr_data=0.
REQ-041 Outputs SHALL hold reset values from the first edge reset is sampled low until the first edge after it goes high.
REQ-042 No gnt SHALL be issued while reset is low.

Verification
REQ-043 req0=1, data0=101101, mode0=0 -> gnt0 one cycle, then 6 cycles sr_shift_en=1 with sr_data[0]=1,0,1,1,0,1, then done=1 with done_id=0; model register = 101101.
REQ-044 req1=1, data1=110010, mode1=1 -> 3 beats, sr_enable=1, sr_data[1:0]=11,00,10, then done with done_id=1; register = 110010.
REQ-045 After reset, req0=req1=1 held -> gnt0 first, then gnt1 exactly 5 cycles after gnt0 (2-bit mode), strictly alternating thereafter.
REQ-046 abort=1 on beat 2 of a 1-bit load -> aborted=1 that cycle, done never asserted, busy=0 next cycle, next tie granted to the other requester.
REQ-047 reset low on beat 3 of a load -> all outputs 0 next cycle; after release, req1 alone -> gnt1 in the first IDLE cycle.
REQ-048 data0 changed from 101101 to 000000 one cycle after gnt0 -> beat sequence still 1,0,1,1,0,1.
